quiz_judge: RTL and testbench



---
 rtl/quiz_judge_pkg.sv | 16 +
 rtl/quiz_judge_if.sv | 28 ++
 rtl/quiz_judge_rise.sv | 27 ++
 rtl/quiz_judge.sv | 159 +++++++++++++++
 tb/tb_quiz_judge.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/quiz_judge_pkg.sv
// quiz_judge_pkg: shared definitions for the quiz judge and the score display.
//   state_t     : FSM state codes reported on state_o (IDLE=0, OPEN=1, LOCKED=2)
//   NUM_PLAYERS : number of player buttons
//   MAX_SCORE   : score ceiling; two BCD digits on the display
package quiz_judge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int NUM_PLAYERS = 4;
   localparam int MAX_SCORE   = 99;

endpackage

// File: rtl/quiz_judge_if.sv
// quiz_judge_if: host/player inputs and display-side outputs of the quiz judge.
//   master : drives start/btn/correct/wrong/clear_scores, observes the outputs
//   slave  : the judge itself
interface quiz_judge_if;

   logic                                   start;
   logic [quiz_judge_pkg::NUM_PLAYERS-1:0] btn;
   logic                                   correct;
   logic                                   wrong;
   logic                                   clear_scores;
   logic [1:0]                             player;
   logic [7:0]                             score;
   logic                                   disp_rst_n;
   logic [1:0]                             state_o;
   logic [7:0]                             timer;
   logic                                   timeout;

   modport master (
      output start, btn, correct, wrong, clear_scores,
      input  player, score, disp_rst_n, state_o, timer, timeout
   );

   modport slave (
      input  start, btn, correct, wrong, clear_scores,
      output player, score, disp_rst_n, state_o, timer, timeout
   );

endinterface

// File: rtl/quiz_judge_rise.sv
// rise_detect: per-bit rising-edge detector.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : level inputs
//   rise       : high for the cycle in which din goes 0 -> 1
module rise_detect #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] hist_r;

   // History of the previous cycle's levels, sampled unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_r <= {WIDTH{1'b0}};
      end else begin
         hist_r <= din;
      end
   end

   assign rise = din & ~hist_r;

endmodule

// File: rtl/quiz_judge.sv
// quiz_judge: first-to-buzz arbitration and score keeping for four players.
//   clkout : clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : quiz_judge_if.slave
//            in  : start, btn[3:0], correct, wrong, clear_scores (levels)
//            out : player, score, disp_rst_n (one-cycle low strobe on every
//                  display change), state_o, timer, timeout
module quiz_judge #(
   parameter int ANSWER_TICKS = 20,
   parameter int CORRECT_PTS  = 10,
   parameter int WRONG_PTS    = 5,
   parameter int MAX_SCORE    = quiz_judge_pkg::MAX_SCORE
) (
   input  logic         clkout,
   input  logic         rst_n,
   quiz_judge_if.slave  bus
);

   import quiz_judge_pkg::*;

   state_t     state_r;
   logic [1:0] player_r;
   logic [7:0] score_r;
   logic       disp_rst_n_r;
   logic [7:0] timer_r;
   logic       timeout_r;
   logic [7:0] scores_r [NUM_PLAYERS];

   logic [7:0] rise_s;
   logic [3:0] btn_rise_s;
   logic       start_rise_s;
   logic       correct_rise_s;
   logic       wrong_rise_s;
   logic       clear_rise_s;
   logic       verdict_s;
   logic [1:0] winner_s;
   logic [7:0] cur_s;
   logic [8:0] add_s;
   logic [8:0] sub_s;
   logic [7:0] new_s;

   rise_detect #(.WIDTH(8)) u_rise (
      .clk   (clkout),
      .rst_n (rst_n),
      .din   ({bus.clear_scores, bus.wrong, bus.correct, bus.start, bus.btn}),
      .rise  (rise_s)
   );

   assign btn_rise_s     = rise_s[3:0];
   assign start_rise_s   = rise_s[4];
   assign correct_rise_s = rise_s[5];
   assign wrong_rise_s   = rise_s[6];
   assign clear_rise_s   = rise_s[7];
   // Simultaneous correct and wrong cancel each other out.
   assign verdict_s      = correct_rise_s ^ wrong_rise_s;

   // Fixed-priority winner: lowest-index rising button.
   always_comb begin
      winner_s = 2'd0;
      casez (btn_rise_s)
         4'b???1: winner_s = 2'd0;
         4'b??10: winner_s = 2'd1;
         4'b?100: winner_s = 2'd2;
         4'b1000: winner_s = 2'd3;
         default: winner_s = 2'd0;
      endcase
   end

   // Saturating verdict result; 9-bit intermediates expose overflow and borrow.
   always_comb begin
      cur_s = scores_r[player_r];
      add_s = {1'b0, cur_s} + 9'(CORRECT_PTS);
      sub_s = {1'b0, cur_s} - 9'(WRONG_PTS);
      new_s = cur_s;
      if (correct_rise_s) begin
         if (add_s > 9'(MAX_SCORE)) begin
            new_s = 8'(MAX_SCORE);
         end else begin
            new_s = add_s[7:0];
         end
      end else begin
         if (sub_s[8]) begin
            new_s = 8'd0;
         end else begin
            new_s = sub_s[7:0];
         end
      end
   end

   // Judge FSM with registered display outputs and score table.
   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         player_r     <= 2'd0;
         score_r      <= 8'd0;
         disp_rst_n_r <= 1'b1;
         timer_r      <= 8'd0;
         timeout_r    <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            scores_r[i] <= 8'd0;
         end
      end else begin
         disp_rst_n_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (start_rise_s) begin
                  state_r   <= OPEN;
                  timer_r   <= 8'(ANSWER_TICKS);
                  timeout_r <= 1'b0;
               end
            end
            OPEN: begin
               if (btn_rise_s != 4'b0000) begin
                  state_r      <= LOCKED;
                  player_r     <= winner_s;
                  score_r      <= scores_r[winner_s];
                  disp_rst_n_r <= 1'b0;
                  timer_r      <= 8'd0;
               end else if (timer_r == 8'd1) begin
                  state_r   <= IDLE;
                  timeout_r <= 1'b1;
                  timer_r   <= 8'd0;
               end else begin
                  timer_r <= timer_r - 8'd1;
               end
            end
            LOCKED: begin
               if (verdict_s) begin
                  state_r      <= IDLE;
                  disp_rst_n_r <= 1'b0;
                  // A clear in the same cycle wins over the verdict below.
                  scores_r[player_r] <= new_s;
                  score_r            <= new_s;
               end
            end
            default: begin
               state_r <= IDLE;
               timer_r <= 8'd0;
            end
         endcase
         // Clearing overrides any score update made above, in every state.
         if (clear_rise_s) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               scores_r[i] <= 8'd0;
            end
            score_r      <= 8'd0;
            disp_rst_n_r <= 1'b0;
         end
      end
   end

   assign bus.player     = player_r;
   assign bus.score      = score_r;
   assign bus.disp_rst_n = disp_rst_n_r;
   assign bus.state_o    = state_r;
   assign bus.timer      = timer_r;
   assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_quiz_judge.sv
// tb_quiz_judge: directed vector table plus hand-written multi-cycle sequences
// for quiz_judge with default parameters.
module tb_quiz_judge;

   typedef struct {
      logic       st;
      logic [3:0] b;
      logic       c;
      logic       w;
      logic       clr;
      logic [1:0] es;
      logic [1:0] ep;
      logic [7:0] esc;
      logic       ed;
      logic [7:0] et;
      logic       eto;
   } vec_t;

   logic clkout;
   logic rst_n;
   int   checks;
   int   failures;
   vec_t vecs [21];
   int   exp_s;
   int   new_v;

   quiz_judge_if bus ();

   quiz_judge #(
      .ANSWER_TICKS (20),
      .CORRECT_PTS  (10),
      .WRONG_PTS    (5),
      .MAX_SCORE    (99)
   ) dut (
      .clkout (clkout),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clkout = 1'b0;
   always #5 clkout = ~clkout;

   task automatic step();
      @(posedge clkout);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int es, input int ep, input int esc,
                          input int ed, input int et, input int eto);
      chk({name, ".state"}, int'(bus.state_o), es);
      chk({name, ".player"}, int'(bus.player), ep);
      chk({name, ".score"}, int'(bus.score), esc);
      chk({name, ".disp_rst_n"}, int'(bus.disp_rst_n), ed);
      chk({name, ".timer"}, int'(bus.timer), et);
      chk({name, ".timeout"}, int'(bus.timeout), eto);
   endtask

   // One full window: open, press b, deliver a verdict, settle.
   task automatic run_window(input logic [3:0] b, input logic is_correct, input int exp_p,
                             input int exp_lock, input int exp_new);
      bus.start = 1'b1;
      step();
      chk("win.open", int'(bus.state_o), 1);
      bus.start = 1'b0;
      bus.btn   = b;
      step();
      chk("win.lock_state", int'(bus.state_o), 2);
      chk("win.lock_player", int'(bus.player), exp_p);
      chk("win.lock_score", int'(bus.score), exp_lock);
      chk("win.lock_disp", int'(bus.disp_rst_n), 0);
      bus.btn = 4'b0000;
      if (is_correct) begin
         bus.correct = 1'b1;
      end else begin
         bus.wrong = 1'b1;
      end
      step();
      chk("win.verdict_state", int'(bus.state_o), 0);
      chk("win.verdict_score", int'(bus.score), exp_new);
      chk("win.verdict_disp", int'(bus.disp_rst_n), 0);
      bus.correct = 1'b0;
      bus.wrong   = 1'b0;
      step();
      chk("win.settle_disp", int'(bus.disp_rst_n), 1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.start        = 1'b0;
      bus.btn          = 4'b0000;
      bus.correct      = 1'b0;
      bus.wrong        = 1'b0;
      bus.clear_scores = 1'b0;

      //           st    btn      c     w     clr    state player score disp timer tmo
      vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0,  1'b1, 8'd20, 1'b0};
      vecs[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0,  1'b1, 8'd19, 1'b0};
      vecs[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0,  1'b1, 8'd18, 1'b0};
      vecs[4]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0,  1'b0, 8'd0,  1'b0};
      vecs[5]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[6]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 1'b0, 8'd0,  1'b0};
      vecs[7]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 1'b1, 8'd0,  1'b0};
      vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 1'b1, 8'd0,  1'b0};
      vecs[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 8'd10, 1'b1, 8'd20, 1'b0};
      vecs[10] = '{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 8'd0,  1'b0, 8'd0,  1'b0};
      vecs[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 8'd0,  1'b0, 8'd0,  1'b0};
      vecs[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 8'd0,  1'b0, 8'd0,  1'b0};
      vecs[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0,  1'b1, 8'd20, 1'b0};
      vecs[16] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0,  1'b0, 8'd0,  1'b0};
      vecs[17] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0,  1'b1, 8'd0,  1'b0};
      vecs[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 1'b0, 8'd0,  1'b0};
      vecs[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd10, 1'b1, 8'd0,  1'b0};

      repeat (2) @(negedge clkout);
      rst_n = 1'b1;
      chk_all("reset", 0, 0, 0, 1, 0, 0);

      // Vector table: inputs applied, one edge, outputs compared.
      for (int k = 0; k < 21; k++) begin
         bus.start        = vecs[k].st;
         bus.btn          = vecs[k].b;
         bus.correct      = vecs[k].c;
         bus.wrong        = vecs[k].w;
         bus.clear_scores = vecs[k].clr;
         step();
         chk_all($sformatf("vec%0d", k), int'(vecs[k].es), int'(vecs[k].ep),
                 int'(vecs[k].esc), int'(vecs[k].ed), int'(vecs[k].et), int'(vecs[k].eto));
      end

      // Player 2 climbs from 10 and saturates at 99.
      exp_s = 10;
      for (int i = 0; i < 10; i++) begin
         new_v = (exp_s + 10 > 99) ? 99 : exp_s + 10;
         run_window(4'b0100, 1'b1, 2, exp_s, new_v);
         exp_s = new_v;
      end
      chk("sat.final", int'(bus.score), 99);

      // Player 2 falls from 99; 4 - 5 must clamp to 0, then stay 0.
      for (int i = 0; i < 21; i++) begin
         new_v = (exp_s < 5) ? 0 : exp_s - 5;
         run_window(4'b0100, 1'b0, 2, exp_s, new_v);
         exp_s = new_v;
      end
      chk("floor.final", int'(bus.score), 0);

      // Player 1 earns 10 points (to be wiped by the clear later).
      run_window(4'b0010, 1'b1, 1, 0, 10);

      // btn[0] held through start never wins; window times out.
      bus.btn = 4'b0001;
      step();
      bus.start = 1'b1;
      step();
      chk_all("held.open", 1, 1, 10, 1, 20, 0);
      bus.start = 1'b0;
      for (int j = 1; j < 20; j++) begin
         step();
         chk($sformatf("held.timer%0d", j), int'(bus.timer), 20 - j);
         chk($sformatf("held.state%0d", j), int'(bus.state_o), 1);
      end
      step();
      chk_all("held.timeout", 0, 1, 10, 1, 0, 1);
      bus.btn = 4'b0000;
      step();
      chk_all("held.idle", 0, 1, 10, 1, 0, 1);

      // Press on the timer==1 cycle beats the timeout.
      bus.start = 1'b1;
      step();
      chk_all("late.open", 1, 1, 10, 1, 20, 0);
      bus.start = 1'b0;
      repeat (19) step();
      chk("late.timer1", int'(bus.timer), 1);
      bus.btn = 4'b1000;
      step();
      chk_all("late.lock", 2, 3, 0, 0, 0, 0);

      // correct and clear_scores together: clear wins, state still leaves LOCKED.
      bus.btn          = 4'b0000;
      bus.correct      = 1'b1;
      bus.clear_scores = 1'b1;
      step();
      chk_all("clrv.hit", 0, 3, 0, 0, 0, 0);
      bus.correct      = 1'b0;
      bus.clear_scores = 1'b0;
      step();
      chk_all("clrv.after", 0, 3, 0, 1, 0, 0);

      // Player 1 was wiped by the clear; wrong keeps it at 0.
      run_window(4'b0010, 1'b0, 1, 0, 0);
      // Player 0 earns 10 before the reset test.
      run_window(4'b0001, 1'b1, 0, 0, 10);

      // Asynchronous reset in the middle of a window.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("rst.pre_timer", int'(bus.timer), 18);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("rst.async", 0, 0, 0, 1, 0, 0);
      @(negedge clkout);
      rst_n = 1'b1;
      step();
      chk_all("rst.after", 0, 0, 0, 1, 0, 0);
      // Player 0's score must have been reset as well.
      run_window(4'b0001, 1'b1, 0, 0, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
